// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit 7-segment scan driver.
// A staging copy of the frame is loaded by update and moved to the active
// copy only when the scan wraps from digit 7 to digit 0, so a digit sweep
// never mixes two frames. Each digit slot opens with a short all-dark gap
// to stop ghosting, and optional leading-zero suppression darkens unused
// high digits.
module seg_scan_driver #(
    parameter int SCAN_DIV    = 1000,
    parameter int BLANK_CYC   = 50,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits,
    input  logic [7:0]  dp,
    input  logic [7:0]  blank,
    input  logic        lz_en,
    input  logic        update,
    output logic [7:0]  seg,
    output logic [7:0]  dig,
    output logic        frame_start
);

    localparam int               CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    // XOR masks that turn an active-high value into the pin level.
    localparam logic [7:0]       SEG_POL   = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0]       DIG_POL   = DIG_ACT_LOW ? 8'hFF : 8'h00;

    // Segment pattern {g,f,e,d,c,b,a} for one hex code, active-high.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        unique case (code)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Slot timing
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    // Staging frame, written by update
    logic             pending_q, pending_d;
    logic [31:0]      stg_digits_q, stg_digits_d;
    logic [7:0]       stg_dp_q, stg_dp_d;
    logic [7:0]       stg_blank_q, stg_blank_d;
    logic             stg_lz_q, stg_lz_d;
    // Active frame, the one being scanned
    logic [31:0]      act_digits_q, act_digits_d;
    logic [7:0]       act_dp_q, act_dp_d;
    logic [7:0]       act_blank_q, act_blank_d;
    logic             act_lz_q, act_lz_d;
    // Registered pins
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       dig_q, dig_d;
    logic             fs_q, fs_d;

    logic             slot_end;
    logic             boundary;
    logic [7:0]       suppress;
    logic             lz_run;
    logic [3:0]       cur_code;
    logic             lit;

    assign slot_end = (cnt_q == CNT_LAST);
    assign boundary = slot_end && (idx_q == 3'd7);
    assign cur_code = act_digits_q[{idx_q, 2'b00} +: 4];

    // Leading-zero suppression: walk down from digit 7 while digits are zero or blanked.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        suppress = 8'h00;
        lz_run   = act_lz_q;
        for (int i = 7; i >= 1; i--) begin
            lz_run      = lz_run && ((act_digits_q[4*i +: 4] == 4'h0) || act_blank_q[i]);
            suppress[i] = lz_run;
        end
    end

    // Whether the digit under the scan pointer is lit this cycle.
    always_comb begin
        lit = (cnt_q >= BLANK_END) && !act_blank_q[idx_q] && !suppress[idx_q];
    end

    // Next-state: slot counters, frame buffer swap, staging load and output stage.
    always_comb begin
        cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d        = slot_end ? idx_q + 3'd1 : idx_q;
        pending_d    = pending_q;
        stg_digits_d = stg_digits_q;
        stg_dp_d     = stg_dp_q;
        stg_blank_d  = stg_blank_q;
        stg_lz_d     = stg_lz_q;
        act_digits_d = act_digits_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        act_lz_d     = act_lz_q;

        // The swap reads the staging contents from before this cycle's update,
        // so an update landing on the boundary waits for the next one.
        if (boundary && pending_q) begin
            act_digits_d = stg_digits_q;
            act_dp_d     = stg_dp_q;
            act_blank_d  = stg_blank_q;
            act_lz_d     = stg_lz_q;
            pending_d    = 1'b0;
        end
        if (update) begin
            stg_digits_d = digits;
            stg_dp_d     = dp;
            stg_blank_d  = blank;
            stg_lz_d     = lz_en;
            pending_d    = 1'b1;
        end

        seg_d = (lit ? {act_dp_q[idx_q], glyph(cur_code)} : 8'h00) ^ SEG_POL;
        dig_d = (lit ? (8'h01 << idx_q) : 8'h00) ^ DIG_POL;
        fs_d  = boundary;
    end

    // State registers with synchronous reset; the display comes up dark.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            pending_q    <= 1'b0;
            stg_digits_q <= 32'h0;
            stg_dp_q     <= 8'h00;
            stg_blank_q  <= 8'h00;
            stg_lz_q     <= 1'b0;
            act_digits_q <= 32'h0;
            act_dp_q     <= 8'h00;
            act_blank_q  <= 8'hFF;
            act_lz_q     <= 1'b0;
            seg_q        <= SEG_POL;
            dig_q        <= DIG_POL;
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            stg_digits_q <= stg_digits_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            stg_lz_q     <= stg_lz_d;
            act_digits_q <= act_digits_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_lz_q     <= act_lz_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            fs_q         <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dig         = dig_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: self-checking bench for seg_scan_driver with
// SCAN_DIV=4, BLANK_CYC=1, active-low digits, active-high segments.
// A reference model pushes the expected pins for every clock into a queue;
// a monitor pops and compares each cycle. Scenario tasks add their own
// targeted checks against hand-written frame patterns.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digits = 32'h0;
    logic [7:0]  dp = 8'h00;
    logic [7:0]  blank = 8'h00;
    logic        lz_en = 1'b0;
    logic        update = 1'b0;
    logic [7:0]  seg;
    logic [7:0]  dig;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .SCAN_DIV   (4),
        .BLANK_CYC  (1),
        .SEG_ACT_LOW(1'b0),
        .DIG_ACT_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp         (dp),
        .blank      (blank),
        .lz_en      (lz_en),
        .update     (update),
        .seg        (seg),
        .dig        (dig),
        .frame_start(frame_start)
    );

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model state
    int          m_cnt, m_idx;
    bit          m_pend;
    logic [31:0] m_digits, s_digits;
    logic [7:0]  m_dp, s_dp, m_blank, s_blank;
    logic        m_lz, s_lz;
    logic [16:0] exp_q [$];   // {frame_start, seg, dig}

    // Digit i is suppressed when no digit from 7 down to i is a visible nonzero.
    function automatic bit model_suppressed(int i);
        if (!m_lz || i == 0) return 1'b0;
        for (int j = 7; j >= i; j--)
            if (m_digits[4*j +: 4] != 4'h0 && !m_blank[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [16:0] model_out();
        logic [7:0] s = 8'h00;
        logic [7:0] d = 8'hFF;
        if (m_cnt >= 1 && !m_blank[m_idx] && !model_suppressed(m_idx)) begin
            s = {m_dp[m_idx], GLYPH[m_digits[4*m_idx +: 4]]};
            d = ~(8'h01 << m_idx);
        end
        return {(m_cnt == 3 && m_idx == 7), s, d};
    endfunction

    // Expected pins for cycle k of a frame given per-digit segments and a lit mask.
    function automatic logic [16:0] slot_expect(int k, logic [63:0] segs, logic [7:0] lit);
        int         idx = k / 4;
        int         cnt = k % 4;
        logic [7:0] s = 8'h00;
        logic [7:0] d = 8'hFF;
        if (cnt >= 1 && lit[idx]) begin
            s = segs[idx*8 +: 8];
            d = ~(8'h01 << idx);
        end
        return {(k == 31), s, d};
    endfunction

    // Reference model: push the expectation for this edge, then advance.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            exp_q.push_back({1'b0, 8'h00, 8'hFF});
            m_cnt = 0; m_idx = 0; m_pend = 1'b0;
            m_digits = 32'h0; s_digits = 32'h0;
            m_dp = 8'h00; s_dp = 8'h00;
            m_blank = 8'hFF; s_blank = 8'h00;
            m_lz = 1'b0; s_lz = 1'b0;
        end else begin
            exp_q.push_back(model_out());
            if (m_cnt == 3 && m_idx == 7 && m_pend) begin
                m_digits = s_digits; m_dp = s_dp; m_blank = s_blank; m_lz = s_lz;
                m_pend = 1'b0;
            end
            if (update) begin
                s_digits = digits; s_dp = dp; s_blank = blank; s_lz = lz_en;
                m_pend = 1'b1;
            end
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt++;
            end
        end
    end

    // Scoreboard monitor: compare pins against the model every falling edge.
    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            if ({frame_start, seg, dig} !== exp_q[0]) begin
                errors++;
                $display("FAIL scoreboard t=%0t got fs=%b seg=%h dig=%h expected fs=%b seg=%h dig=%h",
                         $time, frame_start, seg, dig, exp_q[0][16], exp_q[0][15:8], exp_q[0][7:0]);
            end
            exp_q.delete(0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Returns at the falling edge where frame_start is seen high.
    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 100);
        if (frame_start !== 1'b1) begin
            $display("FAIL frame_start_timeout got none in 100 cycles, required a pulse");
            $fatal(1, "frame_start never arrived");
        end
    endtask

    // Stage a frame at the start of one frame; it becomes active at the next boundary.
    task automatic load_frame(logic [31:0] d, logic [7:0] p, logic [7:0] b, logic lz);
        wait_fs();
        digits = d; dp = p; blank = b; lz_en = lz; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_fs();
    endtask

    task automatic test_reset();
        logic [16:0] e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({frame_start, seg, dig} !== {1'b0, 8'h00, 8'hFF}) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got %h required %h", i, {frame_start, seg, dig}, {1'b0, 8'h00, 8'hFF});
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = {(k == 31), 8'h00, 8'hFF};
            checks++;
            if ({frame_start, seg, dig} !== e) begin
                errors++;
                $display("FAIL post_reset k=%0d got %h required %h", k, {frame_start, seg, dig}, e);
            end
        end
    endtask

    task automatic test_frame();
        logic [63:0] segs = {8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
        logic [16:0] e;
        load_frame(32'h76543210, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = slot_expect(k, segs, 8'hFF);
            checks++;
            if ({frame_start, seg, dig} !== e) begin
                errors++;
                $display("FAIL frame_sweep k=%0d got %h required %h", k, {frame_start, seg, dig}, e);
            end
        end
    endtask

    task automatic test_lz();
        logic [16:0] e;
        load_frame(32'h00000305, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = slot_expect(k, {40'h0, 8'h4F, 8'h3F, 8'h6D}, 8'h07);
            checks++;
            if ({frame_start, seg, dig} !== e) begin
                errors++;
                $display("FAIL lz_305 k=%0d got %h required %h", k, {frame_start, seg, dig}, e);
            end
        end
        // All zeros: only digit 0 survives; the dp of suppressed digit 7 stays dark.
        load_frame(32'h00000000, 8'h81, 8'h00, 1'b1);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = slot_expect(k, {56'h0, 8'hBF}, 8'h01);
            checks++;
            if ({frame_start, seg, dig} !== e) begin
                errors++;
                $display("FAIL lz_zero k=%0d got %h required %h", k, {frame_start, seg, dig}, e);
            end
        end
    endtask

    task automatic test_double_buffer();
        logic [16:0] e;
        wait_fs();
        digits = 32'h11111111; dp = 8'h00; blank = 8'h00; lz_en = 1'b0; update = 1'b1;
        // Old frame (all-zero LZ frame) stays until the boundary.
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = slot_expect(k, {56'h0, 8'hBF}, 8'h01);
            checks++;
            if ({frame_start, seg, dig} !== e) begin
                errors++;
                $display("FAIL db_old k=%0d got %h required %h", k, {frame_start, seg, dig}, e);
            end
            if (k == 0) update = 1'b0;
            if (k == 1) begin digits = 32'h22222222; update = 1'b1; end
            if (k == 2) update = 1'b0;
        end
        // Last update wins; a new update lands exactly on the boundary cycle.
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = slot_expect(k, {8{8'h5B}}, 8'hFF);
            checks++;
            if ({frame_start, seg, dig} !== e) begin
                errors++;
                $display("FAIL db_new k=%0d got %h required %h", k, {frame_start, seg, dig}, e);
            end
            if (k == 30) begin digits = 32'h33333333; update = 1'b1; end
            if (k == 31) update = 1'b0;
        end
        // The boundary-coincident update is held back one frame.
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = slot_expect(k, {8{8'h5B}}, 8'hFF);
            checks++;
            if ({frame_start, seg, dig} !== e) begin
                errors++;
                $display("FAIL db_held k=%0d got %h required %h", k, {frame_start, seg, dig}, e);
            end
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = slot_expect(k, {8{8'h4F}}, 8'hFF);
            checks++;
            if ({frame_start, seg, dig} !== e) begin
                errors++;
                $display("FAIL db_late k=%0d got %h required %h", k, {frame_start, seg, dig}, e);
            end
        end
    endtask

    task automatic test_masks();
        logic [16:0] e;
        load_frame(32'h00000000, 8'h02, 8'h01, 1'b0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = slot_expect(k, {{6{8'h3F}}, 8'hBF, 8'h00}, 8'hFE);
            checks++;
            if ({frame_start, seg, dig} !== e) begin
                errors++;
                $display("FAIL masks k=%0d got %h required %h", k, {frame_start, seg, dig}, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [16:0] e;
        wait_fs();
        for (int k = 0; k < 18; k++) @(negedge clk);
        checks++;
        if ({frame_start, seg, dig} !== {1'b0, 8'h3F, 8'hEF}) begin
            errors++;
            $display("FAIL mid_digit4_lit got %h required %h", {frame_start, seg, dig}, {1'b0, 8'h3F, 8'hEF});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({frame_start, seg, dig} !== {1'b0, 8'h00, 8'hFF}) begin
            errors++;
            $display("FAIL mid_reset got %h required %h", {frame_start, seg, dig}, {1'b0, 8'h00, 8'hFF});
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if ({seg, dig} !== {8'h00, 8'hFF}) begin
                errors++;
                $display("FAIL mid_dark k=%0d got %h required %h", k, {seg, dig}, {8'h00, 8'hFF});
            end
        end
        load_frame(32'h89ABCDEF, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = slot_expect(k, {8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71}, 8'hFF);
            checks++;
            if ({frame_start, seg, dig} !== e) begin
                errors++;
                $display("FAIL mid_reload k=%0d got %h required %h", k, {frame_start, seg, dig}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_lz();
        test_double_buffer();
        test_masks();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
